seq_add_sub: RTL and testbench
==============================

# seq_add_sub

Parametrised multi-cycle adder/subtractor: the next generation of the team's 32-bit full adder. It processes DIGIT bits per clock over WIDTH/DIGIT cycles under a start/busy/done handshake. It supports an add or subtract mode, carry/borrow-in, and a signed-overflow flag. It sits beside the datapath ALU, where a narrow, area-cheap adder is acceptable in exchange for latency.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 8: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  mode: 0 = a+b+cin, 1 = a−b−cin (borrow-in).
- cin  in  1  carry-in (add) / borrow-in (sub).
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- s  out  WIDTH  result; registered and held until the next completion.
- cout  out  1  raw carry-out of MSB; in sub mode 1 = no borrow.
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when s/cout/ovf update.

## Operation
- Two states: IDLE and RUN. N = WIDTH/DIGIT digit steps.
- IDLE with start=1 at an edge:
  - latch a into the A shift register;
  - latch b into the B shift register, or ~b if sub=1;
  - set the carry register to cin, or ~cin if sub=1;
  - clear the digit counter, set busy, go to RUN.
- Subtract is computed as a + ~b + ~cin. Result bits equal (a − b − cin) mod 2^WIDTH.
- RUN, each edge:
  - add the low DIGIT bits of A, B and carry;
  - shift the sum digit into the top of the partial-result register; shift A and B right by DIGIT;
  - update carry; increment the counter.
- Final digit (counter = N−1): also capture the carry into the MSB for ovf.
- On the edge that processes the final digit:
  - copy the partial result to s, carry to cout, and overflow to ovf;
  - assert done for exactly one cycle; clear busy; return to IDLE.
- s/cout/ovf are not disturbed during RUN. They hold the previous result until the next completion.
- start while busy=1 is ignored and not queued. Operand/mode changes during RUN have no effect.
- start=1 in the cycle done=1 is legal: state is already IDLE, so it is accepted.
- rst=1 at any edge, including mid-RUN:
  - state goes to IDLE; the operation is aborted with no done pulse;
  - s=0, cout=0, ovf=0, busy=0, done=0; internal registers and counter cleared.
  - rst has priority over start.
- Arithmetic is modulo 2^WIDTH. cout is the true (WIDTH+1)-th bit of a + b' + c'.

## Timing
- Start accepted at edge k → busy=1 after edge k.
- Digits processed at edges k+1 … k+N.
- After edge k+N: done=1, busy=0, results valid. After edge k+N+1: done=0.
- Latency start→done = N+1 edges; 5 for defaults. Throughput is one operation per N+1 cycles with back-to-back starts.
- DIGIT=WIDTH gives latency 2. DIGIT=1 gives latency WIDTH+1.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Defaults; a=4200000021, b=980000, sub=0, cin=0 → s=4200980021, cout=0, ovf=0. Check done exactly 5 edges after start, 1 cycle wide, and busy high for 4 cycles.
- a=4294967295, b=1, cin=0 → s=0, cout=1, ovf=0. Then a=0x7FFFFFFF, b=1 → s=0x80000000, cout=0, ovf=1. Then a=b=4294967295, cin=1 → s=4294967295, cout=1.
- sub=1: a=5, b=7, cin=0 → s=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=1, cin=0 → s=0x7FFFFFFF, cout=1, ovf=1. Then a=10, b=3, cin=1 → s=6, cout=1.
- Handshake:
  - start pulsed again mid-RUN with different operands → ignored, first result unchanged;
  - start held high through done → second op accepted the cycle done=1, second done 5 edges later;
  - s holds the old value during RUN.
- rst asserted at the 3rd RUN edge → no done pulse, all outputs 0 after the edge. A new op after deassert completes correctly.
- Parameters WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001 → s=0, cout=1, latency 5. WIDTH=16, DIGIT=16: a=0x1234, b=0x4321 → s=0x5555, latency 2.

Source files
------------

// File: rtl/seq_add_sub.sv
// ---------------------------------------------------------------------------
// seq_add_sub
//
// Multi-cycle adder/subtractor. It processes DIGIT bits per clock over
// N = WIDTH/DIGIT clocks. A start/busy/done handshake controls each
// operation.
//
//   add : s = a + b + cin
//   sub : s = a - b - cin, computed as a + ~b + ~cin
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   operation request, sampled only while idle
//   sub    in   0 = add, 1 = subtract
//   cin    in   carry-in (add) / borrow-in (sub)
//   a, b   in   WIDTH-bit operands (unsigned or two's complement)
//   s      out  registered result, held until the next completion
//   cout   out  raw carry-out of the MSB (in sub mode 1 = no borrow)
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)
//   busy   out  operation in progress
//   done   out  one-cycle pulse when s/cout/ovf update
// ---------------------------------------------------------------------------
module seq_add_sub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   digit_sum;
    logic             msb_carry_in;

    // Digit adder plus the next-state logic for the IDLE/RUN controller.
    // In RUN, each step consumes the low digit of A and B. The sum digit is
    // pushed into the top of the partial result, so after N steps the first
    // digit has reached bit 0. On the last step, the carry into the MSB is
    // recovered from the sum bit: a ^ b ^ s at that bit position.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        digit_sum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry_q};
        msb_carry_in = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                part_d  = (part_q >> DIGIT)
                          | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                if (cnt_q == LAST_DIGIT) begin
                    s_d     = part_d;
                    cout_d  = digit_sum[DIGIT];
                    ovf_d   = msb_carry_in ^ digit_sum[DIGIT];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset clears everything, which aborts
    // any operation in flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_seq_add_sub.sv
// ---------------------------------------------------------------------------
// tb_seq_add_sub
//
// Scoreboard bench for seq_add_sub. It drives three instances:
//   dut32  : WIDTH=32, DIGIT=8  (default geometry)
//   dut16  : WIDTH=16, DIGIT=4
//   dut16w : WIDTH=16, DIGIT=16 (single-digit, latency 2)
// The stimulus pushes hand-computed expected results into one queue per
// instance. A monitor per instance pops the queue and compares whenever
// done is seen.
// ---------------------------------------------------------------------------
module tb_seq_add_sub;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        start32, sub32, cin32;
    logic [31:0] a32, b32, s32;
    logic        cout32, ovf32, busy32, done32;

    logic        start16, sub16, cin16;
    logic [15:0] a16, b16, s16, s16w;
    logic        cout16, ovf16, busy16, done16;
    logic        cout16w, ovf16w, busy16w, done16w;

    exp_t        q32[$];
    exp_t        q16[$];
    exp_t        q16w[$];

    int          total;
    int          bad;
    logic [31:0] prevS32;

    seq_add_sub #(.WIDTH(32), .DIGIT(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .cin(cin32),
        .a(a32), .b(b32), .s(s32), .cout(cout32), .ovf(ovf32),
        .busy(busy32), .done(done32)
    );

    seq_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .s(s16), .cout(cout16), .ovf(ovf16),
        .busy(busy16), .done(done16)
    );

    seq_add_sub #(.WIDTH(16), .DIGIT(16)) dut16w (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .s(s16w), .cout(cout16w), .ovf(ovf16w),
        .busy(busy16w), .done(done16w)
    );

    // 10-unit clock period; rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net, so that a stuck design cannot hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL timeout: got no end of test, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // A single comparison. It counts the check and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: each done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done32: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q32.pop_front();
                checkOutput("s32", s32, e.s);
                checkOutput("cout32", cout32, e.cout);
                checkOutput("ovf32", ovf32, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done16: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q16.pop_front();
                checkOutput("s16", {16'h0, s16}, e.s);
                checkOutput("cout16", cout16, e.cout);
                checkOutput("ovf16", ovf16, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (done16w === 1'b1) begin
            if (q16w.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done16w: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q16w.pop_front();
                checkOutput("s16w", {16'h0, s16w}, e.s);
                checkOutput("cout16w", cout16w, e.cout);
                checkOutput("ovf16w", ovf16w, e.ovf);
            end
        end
    end

    // One complete 32-bit operation. The task queues the expected result,
    // checks the 5-edge latency, the 4 busy cycles and the 1-cycle done
    // pulse, and checks that s holds the previous result while busy.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv, input logic cv,
                                 input logic [31:0] es, input logic ec,
                                 input logic eo);
        exp_t e;
        int   edges;
        int   busyCycles;
        @(negedge clk);
        a32 = av; b32 = bv; sub32 = sv; cin32 = cv; start32 = 1'b1;
        e.s = es; e.cout = ec; e.ovf = eo;
        q32.push_back(e);
        edges = 0;
        busyCycles = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start32 = 1'b0;
            if (busy32 === 1'b1) begin
                busyCycles++;
                checkOutput("s_hold", s32, prevS32);
            end
        end while (done32 !== 1'b1 && edges < 20);
        checkOutput("latency32", edges, 5);
        checkOutput("busy_cycles32", busyCycles, 4);
        prevS32 = es;
        @(negedge clk);
        checkOutput("done_width32", done32, 0);
    endtask

    initial begin
        exp_t e;
        int   edges;
        int   lat16;
        int   lat16w;

        total = 0; bad = 0; prevS32 = '0;
        rst = 1'b1;
        start32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
        $display("[TB] starting seq_add_sub bench");

        repeat (3) @(negedge clk);
        checkOutput("rst_s32", s32, 0);
        checkOutput("rst_cout32", cout32, 0);
        checkOutput("rst_ovf32", ovf32, 0);
        checkOutput("rst_busy32", busy32, 0);
        checkOutput("rst_done32", done32, 0);
        checkOutput("rst_busy16", busy16, 0);
        checkOutput("rst_busy16w", busy16w, 0);
        rst = 1'b0;

        // Addition vectors
        applyStimulus(32'd4200000021, 32'd980000, 1'b0, 1'b0, 32'd4200980021, 1'b0, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        // Subtraction vectors
        applyStimulus(32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        applyStimulus(32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
        applyStimulus(32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);

        // Reset on the third RUN edge: the op is aborted with no done pulse.
        @(negedge clk);
        a32 = 32'h1000; b32 = 32'h2000; sub32 = 1'b0; cin32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_s32", s32, 0);
        checkOutput("abort_cout32", cout32, 0);
        checkOutput("abort_ovf32", ovf32, 0);
        checkOutput("abort_busy32", busy32, 0);
        checkOutput("abort_done32", done32, 0);
        rst = 1'b0;
        prevS32 = '0;
        repeat (6) @(negedge clk);
        checkOutput("abort_no_done32", done32, 0);
        applyStimulus(32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0);

        // A start pulse mid-RUN with other operands is ignored.
        @(negedge clk);
        a32 = 32'd1; b32 = 32'd2; sub32 = 1'b0; cin32 = 1'b0; start32 = 1'b1;
        e.s = 32'd3; e.cout = 1'b0; e.ovf = 1'b0;
        q32.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        @(negedge clk);
        a32 = 32'd100; b32 = 32'd200; sub32 = 1'b1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        edges = 0;
        while (done32 !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("ignored_start_done", done32, 1);
        repeat (8) @(negedge clk);
        checkOutput("ignored_start_idle", busy32, 0);

        // Start is held high through done, so the second op is accepted at once.
        @(negedge clk);
        a32 = 32'h11; b32 = 32'h22; sub32 = 1'b0; cin32 = 1'b0; start32 = 1'b1;
        e.s = 32'h33; e.cout = 1'b0; e.ovf = 1'b0;
        q32.push_back(e);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (done32 !== 1'b1 && edges < 20);
        checkOutput("held_latency1", edges, 5);
        a32 = 32'h100; b32 = 32'h5;
        e.s = 32'h105; e.cout = 1'b0; e.ovf = 1'b0;
        q32.push_back(e);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start32 = 1'b0;
        end while (done32 !== 1'b1 && edges < 20);
        checkOutput("held_latency2", edges, 5);

        // Other geometries: 16/4 (latency 5) and 16/16 (latency 2).
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
        e.s = 32'h0; e.cout = 1'b1; e.ovf = 1'b0;
        q16.push_back(e);
        e.s = 32'h0; e.cout = 1'b1; e.ovf = 1'b0;
        q16w.push_back(e);
        lat16 = 0; lat16w = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            start16 = 1'b0;
            if (done16 === 1'b1 && lat16 == 0) lat16 = i;
            if (done16w === 1'b1 && lat16w == 0) lat16w = i;
        end
        checkOutput("latency16", lat16, 5);
        checkOutput("latency16w", lat16w, 2);

        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
        e.s = 32'h5555; e.cout = 1'b0; e.ovf = 1'b0;
        q16.push_back(e);
        q16w.push_back(e);
        lat16w = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            start16 = 1'b0;
            if (done16w === 1'b1 && lat16w == 0) lat16w = i;
        end
        checkOutput("latency16w_b", lat16w, 2);

        repeat (8) @(negedge clk);
        checkOutput("sb_empty32", q32.size(), 0);
        checkOutput("sb_empty16", q16.size(), 0);
        checkOutput("sb_empty16w", q16w.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
